quadrature_step_decoder: RTL and testbench

//   Converts the two-phase quadrature signals from an incremental encoder into

---
 rtl/quadrature_step_decoder.sv | 156 +++++++++++++++
 tb/tb_quadrature_step_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_step_decoder.sv
`default_nettype none
// ============================================================================
// Module      : quadrature_step_decoder
// Description : Synchronises, glitch-filters and decodes two-phase quadrature
//               inputs into step pulses, a direction level and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module quadrature_step_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int ERR_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 quad_a,
  input  logic                 quad_b,
  input  logic                 clear_err,
  output logic                 step,
  output logic                 dir,
  output logic                 err,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam int CNT_W  = $clog2(FILTER_CYCLES + 1);
  localparam int INIT_W = $clog2(SYNC_STAGES + FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0]  c_FILT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [INIT_W-1:0] c_INIT_LAST = INIT_W'(SYNC_STAGES + FILTER_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [INIT_W-1:0]     r_init_cnt, w_init_nxt;
  logic [1:0]            w_raw, w_synced, w_filt, r_prev, w_delta;
  logic                  w_load;
  logic                  r_step, r_dir, r_err;
  logic                  w_step_nxt, w_dir_nxt, w_err_nxt;
  logic [ERR_WIDTH-1:0]  r_err_count, w_errcnt_nxt;

  // Bit 1 carries phase A, bit 0 phase B, so AB reads as a 2-bit code.
  assign w_raw = {quad_a, quad_b};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_filt;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync <= '0;
        r_cnt  <= '0;
        r_filt <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
        if (w_load) begin
          r_filt <= w_synced[gi];
          r_cnt  <= '0;
        end else if (w_synced[gi] == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == c_FILT_LAST) begin
          r_filt <= w_synced[gi];
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    assign w_synced[gi] = r_sync[SYNC_STAGES-1];
    assign w_filt[gi]   = r_filt;
  end

  // Position along the up sequence 00->10->11->01, so a +1 step is "up".
  function automatic logic [1:0] f_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   f_pos = 2'd0;
      2'b10:   f_pos = 2'd1;
      2'b11:   f_pos = 2'd2;
      default: f_pos = 2'd3;
    endcase
  endfunction

  assign w_delta = f_pos(w_filt) - f_pos(r_prev);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_prev      <= 2'b00;
      r_step      <= 1'b0;
      r_dir       <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_init_nxt;
      r_step      <= w_step_nxt;
      r_dir       <= w_dir_nxt;
      r_err       <= w_err_nxt;
      r_err_count <= w_errcnt_nxt;
      if (w_load)
        r_prev <= w_synced;
      else if (r_state == ST_TRACK)
        r_prev <= w_filt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_init_nxt   = r_init_cnt;
    w_load       = 1'b0;
    w_step_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_dir_nxt    = r_dir;
    w_errcnt_nxt = r_err_count;
    case (r_state)
      ST_INIT: begin
        // Synced levels are trustworthy by now; adopt them without filtering.
        if (r_init_cnt == c_INIT_LAST) begin
          w_load      = 1'b1;
          w_state_nxt = ST_TRACK;
        end else begin
          w_init_nxt = r_init_cnt + INIT_W'(1);
        end
      end
      ST_TRACK: begin
        case (w_delta)
          2'd1: begin
            w_step_nxt = 1'b1;
            w_dir_nxt  = 1'b0;
          end
          2'd3: begin
            w_step_nxt = 1'b1;
            w_dir_nxt  = 1'b1;
          end
          2'd2:    w_err_nxt = 1'b1;
          default: ;
        endcase
      end
      default: w_state_nxt = ST_INIT;
    endcase
    if (clear_err)
      w_errcnt_nxt = '0;
    else if (w_err_nxt && (r_err_count != {ERR_WIDTH{1'b1}}))
      w_errcnt_nxt = r_err_count + ERR_WIDTH'(1);
  end

  assign step      = r_step;
  assign dir       = r_dir;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_quadrature_step_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_quadrature_step_decoder
// Description : Directed self-checking bench for quadrature_step_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quadrature_step_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       quad_a = 1'b0;
  logic       quad_b = 1'b0;
  logic       clear_err = 1'b0;
  logic       step, dir, err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int n_step, n_up, n_dn, n_err;
  int n_both = 0;
  int n_dirbad = 0;
  logic first_dir, last_dir;
  logic prev_dir = 1'b0;

  quadrature_step_decoder #(
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(4),
    .ERR_WIDTH    (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .clear_err(clear_err),
    .step     (step),
    .dir      (dir),
    .err      (err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // One clock: observe outputs 1 time unit after the edge, then return so the
  // caller can drive new inputs for the following edge.
  task automatic cyc();
    logic rst_edge;
    @(posedge clk);
    rst_edge = reset;
    #1;
    if (step === 1'b1) begin
      if (n_step == 0) first_dir = dir;
      last_dir = dir;
      n_step++;
      if (dir === 1'b1) n_dn++;
      else n_up++;
    end
    if (err === 1'b1) n_err++;
    if (step === 1'b1 && err === 1'b1) n_both++;
    if (!rst_edge && step !== 1'b1 && dir !== prev_dir) n_dirbad++;
    prev_dir = dir;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clr_counts();
    n_step = 0; n_up = 0; n_dn = 0; n_err = 0;
    first_dir = 1'bx; last_dir = 1'bx;
  endtask

  task automatic set_ab(input logic a, input logic b);
    quad_a = a;
    quad_b = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_ab(1'b1, 1'b1);
    cycles(3);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got=%b exp=0", step); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b exp=0", dir); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got=%0d exp=0", err_count); end
    reset = 1'b0;
    clr_counts();
    cycles(20);
    checks++; if (n_step != 0) begin errors++; $display("FAIL reset11_steps got=%0d exp=0", n_step); end
    checks++; if (n_err != 0) begin errors++; $display("FAIL reset11_errs got=%0d exp=0", n_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset11_errcnt got=%0d exp=0", err_count); end
    checks++; if (dut.r_state !== 1'b1) begin errors++; $display("FAIL reset11_track got=%b exp=1", dut.r_state); end
    // Re-initialise at AB=00 so the sequence tests start from a known level.
    reset = 1'b1;
    set_ab(1'b0, 1'b0);
    cycles(2);
    reset = 1'b0;
    clr_counts();
    cycles(20);
    checks++; if (n_step != 0 || n_err != 0) begin errors++; $display("FAIL reset00_quiet got=%0d/%0d exp=0/0", n_step, n_err); end
  endtask

  task automatic test_up();
    clr_counts();
    quad_a = 1'b1;
    cycles(6);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL up_early got=%b exp=0", step); end
    cyc();
    checks++; if (step !== 1'b1 || dir !== 1'b0) begin errors++; $display("FAIL up_latency7 got=%b%b exp=10", step, dir); end
    cycles(3);
    set_ab(1'b1, 1'b1); cycles(10);
    set_ab(1'b0, 1'b1); cycles(10);
    set_ab(1'b0, 1'b0); cycles(10);
    checks++; if (n_up != 4) begin errors++; $display("FAIL up_count got=%0d exp=4", n_up); end
    checks++; if (n_dn != 0) begin errors++; $display("FAIL up_down_count got=%0d exp=0", n_dn); end
    checks++; if (n_err != 0) begin errors++; $display("FAIL up_errs got=%0d exp=0", n_err); end
  endtask

  task automatic test_down();
    clr_counts();
    set_ab(1'b0, 1'b1); cycles(10);
    set_ab(1'b1, 1'b1); cycles(10);
    set_ab(1'b1, 1'b0); cycles(10);
    set_ab(1'b0, 1'b0); cycles(20);
    checks++; if (n_dn != 4) begin errors++; $display("FAIL down_count got=%0d exp=4", n_dn); end
    checks++; if (n_up != 0) begin errors++; $display("FAIL down_up_count got=%0d exp=0", n_up); end
    checks++; if (n_err != 0) begin errors++; $display("FAIL down_errs got=%0d exp=0", n_err); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL down_dir_held got=%b exp=1", dir); end
  endtask

  task automatic test_glitch();
    clr_counts();
    quad_a = 1'b1; cycles(3);
    quad_a = 1'b0; cycles(15);
    checks++; if (n_step != 0 || n_err != 0) begin errors++; $display("FAIL glitch3 got=%0d/%0d exp=0/0", n_step, n_err); end
    quad_a = 1'b1; cycles(4);
    quad_a = 1'b0; cycles(20);
    checks++; if (n_up != 1 || n_dn != 1) begin errors++; $display("FAIL pulse4_counts got=%0d/%0d exp=1/1", n_up, n_dn); end
    checks++; if (first_dir !== 1'b0 || last_dir !== 1'b1) begin errors++; $display("FAIL pulse4_order got=%b%b exp=01", first_dir, last_dir); end
  endtask

  task automatic test_err();
    logic a;
    clr_counts();
    set_ab(1'b1, 1'b1);
    cycles(6);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early got=%b exp=0", err); end
    cyc();
    checks++; if (err !== 1'b1 || step !== 1'b0) begin errors++; $display("FAIL err_pulse got=%b%b exp=10", err, step); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL err_count1 got=%0d exp=1", err_count); end
    cyc();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b exp=0", err); end
    cycles(4);
    a = 1'b1;
    for (int i = 0; i < 299; i++) begin
      a = ~a;
      set_ab(a, a);
      cycles(8);
    end
    cycles(10);
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_saturate got=%0d exp=255", err_count); end
    checks++; if (n_err != 300) begin errors++; $display("FAIL err_pulses got=%0d exp=300", n_err); end
    checks++; if (n_step != 0) begin errors++; $display("FAIL err_no_step got=%0d exp=0", n_step); end
    clear_err = 1'b1; cyc(); clear_err = 1'b0;
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL err_clear got=%0d exp=0", err_count); end
    set_ab(1'b1, 1'b1);
    cycles(6);
    clear_err = 1'b1; cyc(); clear_err = 1'b0;
    checks++; if (err !== 1'b1 || err_count !== 8'd0) begin errors++; $display("FAIL clear_wins got=%b/%0d exp=1/0", err, err_count); end
    cycles(10);
  endtask

  task automatic test_reset_mid();
    clr_counts();
    set_ab(1'b1, 1'b0); cycles(10);
    set_ab(1'b1, 1'b1); cycles(6);
    reset = 1'b1;
    cyc();
    checks++; if (step !== 1'b0 || dir !== 1'b0 || err !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL midreset_outputs got=%b%b%b/%0d exp=000/0", step, dir, err, err_count);
    end
    cycles(2);
    reset = 1'b0;
    clr_counts();
    cycles(30);
    checks++; if (n_step != 0 || n_err != 0) begin errors++; $display("FAIL midreset_quiet got=%0d/%0d exp=0/0", n_step, n_err); end
    set_ab(1'b0, 1'b1); cycles(10);
    checks++; if (n_up != 1 || n_dn != 0) begin errors++; $display("FAIL midreset_resume got=%0d/%0d exp=1/0", n_up, n_dn); end
  endtask

  task automatic test_invariants();
    checks++; if (n_both != 0) begin errors++; $display("FAIL step_and_err got=%0d exp=0", n_both); end
    checks++; if (n_dirbad != 0) begin errors++; $display("FAIL dir_without_step got=%0d exp=0", n_dirbad); end
  endtask

  initial begin
    clr_counts();
    test_reset();
    test_up();
    test_down();
    test_glitch();
    test_err();
    test_reset_mid();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
